// File: rtl/pbs_seg_pkg.sv
// Shared 7-segment constants and FSM state type for the decimal display decoders.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package pbs_seg_pkg;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0011000   // 9
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LATCH
  } state_t;

  // Internal BCD digit count: enough headroom that double-dabble never overflows.
  function automatic int num_int_digits(input int width);
    return (width + 2) / 3 + 1;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Dash has priority over blank; non-decimal codes show blank.
module seg7_dec
  import pbs_seg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    if (dash) begin
      seg = SEG_DASH;
    end else if (blank || (digit > 4'd9)) begin
      seg = SEG_BLANK;
    end else begin
      seg = SEG_DIGIT[digit];
    end
  end

endmodule

// File: rtl/bcd_seg_display.sv
// Sequential double-dabble binary-to-BCD converter driving a bank of 7-segment digits.
// Optional leading-zero blanking is enabled by defining BCD_SEG_LZB_EN.
module bcd_seg_display
  import pbs_seg_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int NI = num_int_digits(WIDTH);
  localparam int NE = (NI > DIGITS) ? NI : DIGITS;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
    $error("bcd_seg_display: WIDTH must be in 4..16");
  end
  if (DIGITS < 1 || DIGITS > 5) begin : g_bad_digits
    $error("bcd_seg_display: DIGITS must be in 1..5");
  end

  state_t                 state, state_next;
  logic [WIDTH-1:0]       shreg;
  logic [4*NI-1:0]        bcd_int;
  logic [4*NI-1:0]        bcd_adj;
  logic [4*NI+WIDTH-1:0]  shifted;
  logic [CW-1:0]          cnt;
  logic [4*NE-1:0]        bcd_ext;
  logic                   ovf_next;
  logic [DIGITS-1:0]      blank;
  logic [7*DIGITS-1:0]    seg_next;

  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets a default before the case so every path assigns it;
  // a missing default in always_comb infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CONV;
      CONV:    if (cnt == CNT_LAST) state_next = LATCH;
      LATCH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction on every digit >= 5, then one left shift of {bcd, binary}.
  always_comb begin
    bcd_adj = bcd_int;
    for (int i = 0; i < NI; i++) begin
      if (bcd_int[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_int[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, shreg} << 1;
  end

  // Zero-extend so DIGITS may exceed the internal digit count for narrow WIDTH.
  always_comb begin
    bcd_ext = '0;
    bcd_ext[4*NI-1:0] = bcd_int;
  end

  always_comb begin
    ovf_next = 1'b0;
    for (int i = DIGITS; i < NI; i++) begin
      ovf_next = ovf_next | (bcd_ext[4*i +: 4] != 4'd0);
    end
  end

`ifdef BCD_SEG_LZB_EN
  logic lzb_zero;

  // Scan from the top digit down; blank while every digit so far is zero.
  always_comb begin
    lzb_zero = 1'b1;
    blank    = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lzb_zero = lzb_zero & (bcd_ext[4*i +: 4] == 4'd0);
      blank[i] = lzb_zero;
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_dec u_dec (
      .digit (bcd_ext[4*g +: 4]),
      .blank (blank[g]),
      .dash  (ovf_next),
      .seg   (seg_next[7*g +: 7])
    );
  end

  // Visible outputs only move in LATCH so the display holds steady mid-conversion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= '0;
      bcd_int <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      bcd     <= '0;
      seg     <= {DIGITS{SEG_DIGIT[0]}};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= value;
            bcd_int <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
          end
        end
        CONV: begin
          {bcd_int, shreg} <= shifted;
          cnt              <= cnt + 1'b1;
        end
        LATCH: begin
          bcd  <= bcd_ext[4*DIGITS-1:0];
          ovf  <= ovf_next;
          seg  <= seg_next;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seg_display.sv
// Self-checking bench for bcd_seg_display: a 3-digit and a 2-digit instance share stimulus.
// Expected digits come from plain division by powers of ten.
module tb_bcd_seg_display;

  localparam int WIDTH = 8;

  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] S_DASH  = 7'b0111111;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [WIDTH-1:0] value;

  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic [20:0] seg3;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;
  logic [13:0] seg2;

  int tests = 0;
  int fails = 0;
  int last_v = 0;

  always #5 clk = ~clk;

  bcd_seg_display #(.WIDTH(WIDTH), .DIGITS(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .start(start), .value(value),
    .busy(busy3), .done(done3), .ovf(ovf3), .bcd(bcd3), .seg(seg3)
  );

  bcd_seg_display #(.WIDTH(WIDTH), .DIGITS(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .value(value),
    .busy(busy2), .done(done2), .ovf(ovf2), .bcd(bcd2), .seg(seg2)
  );

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0011000;
    endcase
  endfunction

  function automatic int pow10(input int n);
    int p = 1;
    repeat (n) p = p * 10;
    return p;
  endfunction

  function automatic logic [19:0] m_bcd(input int v, input int nd);
    logic [19:0] r = '0;
    for (int i = 0; i < nd; i++) r = r | (20'((v / pow10(i)) % 10) << (4 * i));
    return r;
  endfunction

  function automatic logic m_ovf(input int v, input int nd);
    return v >= pow10(nd);
  endfunction

  function automatic logic [34:0] m_seg(input int v, input int nd);
    logic [34:0] r = '0;
    for (int i = 0; i < nd; i++) begin
      logic [6:0] s;
      if (v >= pow10(nd)) s = S_DASH;
`ifdef BCD_SEG_LZB_EN
      else if (i > 0 && v < pow10(i)) s = S_BLANK;
`endif
      else s = seg_of((v / pow10(i)) % 10);
      r[7*i +: 7] = s;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input int v);
    logic [19:0] eb3, eb2;
    logic [34:0] es3, es2;
    eb3 = m_bcd(v, 3);
    eb2 = m_bcd(v, 2);
    es3 = m_seg(v, 3);
    es2 = m_seg(v, 2);
    check("bcd3", 64'(bcd3), 64'(eb3[11:0]));
    check("seg3", 64'(seg3), 64'(es3[20:0]));
    check("ovf3", 64'(ovf3), 64'(m_ovf(v, 3)));
    check("bcd2", 64'(bcd2), 64'(eb2[7:0]));
    check("seg2", 64'(seg2), 64'(es2[13:0]));
    check("ovf2", 64'(ovf2), 64'(m_ovf(v, 2)));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 64'({busy3, busy2}), 64'(0));
    check({tag, "_done"}, 64'({done3, done2}), 64'(0));
    check({tag, "_ovf"},  64'({ovf3, ovf2}),   64'(0));
    check({tag, "_bcd3"}, 64'(bcd3), 64'(0));
    check({tag, "_bcd2"}, 64'(bcd2), 64'(0));
    check({tag, "_seg3"}, 64'(seg3), 64'({3{7'b1000000}}));
    check({tag, "_seg2"}, 64'(seg2), 64'({2{7'b1000000}}));
  endtask

  // One conversion: start pulse, bounded wait for done, latency and result checks.
  task automatic run_conv(input int v);
    int n;
    start = 1'b1;
    value = WIDTH'(v);
    tick();
    start = 1'b0;
    value = WIDTH'($urandom);
    n = 1;
    while (!done3 && n < 40) begin
      tick();
      n++;
    end
    check("latency", 64'(n), 64'(WIDTH + 2));
    check("done2_sync", 64'(done2), 64'(1));
    check("busy_at_done", 64'(busy3), 64'(0));
    check_result(v);
    last_v = v;
    tick();
    check("done_single", 64'(done3), 64'(0));
  endtask

  // start held high; the model accepts a start every WIDTH+2 cycles.
  task automatic back_to_back(input int nconv, input bit sweep);
    int q[$];
    int v;
    int period = WIDTH + 2;
    start = 1'b1;
    for (int c = 0; c < nconv * period; c++) begin
      if (c % period == 0) begin
        v = sweep ? (c / period) : int'($urandom_range(0, 255));
        value = WIDTH'(v);
        q.push_back(v);
      end else begin
        value = WIDTH'($urandom);
      end
      tick();
      check("b2b_done", 64'(done3), 64'(c % period == period - 1));
      check("b2b_busy", 64'(busy3), 64'(c % period != period - 1));
      if (c % period == period - 1) begin
        v = q.pop_front();
        check_result(v);
        last_v = v;
      end
    end
    start = 1'b0;
    tick();
  endtask

  typedef struct {
    int          v;
    logic [11:0] bcd3;
    logic [7:0]  bcd2;
    logic        ovf2;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [19:0] hold_bcd;
    int done_cnt;

    vecs[0] = '{0,   12'h000, 8'h00, 1'b0};
    vecs[1] = '{7,   12'h007, 8'h07, 1'b0};
    vecs[2] = '{9,   12'h009, 8'h09, 1'b0};
    vecs[3] = '{10,  12'h010, 8'h10, 1'b0};
    vecs[4] = '{42,  12'h042, 8'h42, 1'b0};
    vecs[5] = '{99,  12'h099, 8'h99, 1'b0};
    vecs[6] = '{100, 12'h100, 8'h00, 1'b1};
    vecs[7] = '{105, 12'h105, 8'h05, 1'b1};
    vecs[8] = '{200, 12'h200, 8'h00, 1'b1};
    vecs[9] = '{255, 12'h255, 8'h55, 1'b1};

    reset_n = 1'b0;
    start   = 1'b0;
    value   = '0;
    tick();
    tick();
    check_reset_state("reset");
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_conv(vecs[i].v);
      check("tbl_bcd3", 64'(bcd3), 64'(vecs[i].bcd3));
      check("tbl_bcd2", 64'(bcd2), 64'(vecs[i].bcd2));
      check("tbl_ovf2", 64'(ovf2), 64'(vecs[i].ovf2));
      check("tbl_ovf3", 64'(ovf3), 64'(0));
    end

    run_conv(255);
    check("seg_255", 64'(seg3), 64'({7'b0100100, 7'b0010010, 7'b0010010}));
    run_conv(100);
    check("ovf_dash", 64'(seg2), 64'({S_DASH, S_DASH}));
    check("ovf_bcd", 64'(bcd2), 64'(8'h00));

`ifdef BCD_SEG_LZB_EN
    run_conv(7);
    check("lzb_7", 64'(seg3), 64'({S_BLANK, S_BLANK, 7'b1111000}));
    run_conv(0);
    check("lzb_0", 64'(seg3), 64'({S_BLANK, S_BLANK, 7'b1000000}));
    run_conv(105);
    check("lzb_105", 64'(seg3), 64'({7'b1111001, 7'b1000000, 7'b0010010}));
`else
    run_conv(7);
    check("lz_7", 64'(seg3), 64'({7'b1000000, 7'b1000000, 7'b1111000}));
    run_conv(0);
    check("lz_0", 64'(seg3), 64'({3{7'b1000000}}));
`endif

    // start while busy and during LATCH must be ignored.
    hold_bcd = m_bcd(last_v, 3);
    start = 1'b1;
    value = WIDTH'(42);
    tick();
    check("ign_busy_1", 64'(busy3), 64'(1));
    done_cnt = 0;
    for (int n = 2; n <= 14; n++) begin
      start = (n == 3 || n == 10);
      value = (n == 3 || n == 10) ? WIDTH'(99) : WIDTH'($urandom);
      tick();
      if (done3) done_cnt++;
      check("ign_busy", 64'(busy3), 64'(n <= WIDTH + 1));
      check("ign_done", 64'(done3), 64'(n == WIDTH + 2));
      if (n <= WIDTH + 1) check("ign_hold", 64'(bcd3), 64'(hold_bcd[11:0]));
    end
    start = 1'b0;
    check("ign_done_cnt", 64'(done_cnt), 64'(1));
    check("ign_bcd", 64'(bcd3), 64'(12'h042));
    last_v = 42;

    // Asynchronous abort mid-conversion.
    run_conv(7);
    start = 1'b1;
    value = WIDTH'(200);
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check_reset_state("abort");
    for (int n = 0; n < 3; n++) begin
      tick();
      check("abort_no_done", 64'({done3, done2}), 64'(0));
    end
    reset_n = 1'b1;
    tick();
    check("abort_idle_busy", 64'(busy3), 64'(0));
    run_conv(200);
    check("after_abort", 64'(bcd3), 64'(12'h200));

    back_to_back(256, 1'b1);
    back_to_back(100, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
